// File: rtl/mem_write_checker.sv
// mem_write_checker
// -----------------------------------------------------------------------------
// Watches the store stream of a processor under test and reports a one-hot
// verdict. After `en` it enters RUN and classifies every store:
//   * the magic store (PASS_ADDR, PASS_DATA)        -> PASS
//   * a store inside the scratch window              -> counted, stay in RUN
//   * anything else (incl. unknown bus bits)         -> FAIL (store captured)
// An optional cycle limit moves RUN to TMO. Terminal states are sticky until
// `clr` or `reset`.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset (forces IDLE, all outputs 0)
//   en         start checking when in IDLE
//   clr        synchronous return to IDLE, clears counters and captures
//   MemWrite   store strobe (X is treated as 0)
//   DataAdr    store address, XLEN bits
//   WriteData  store data, XLEN bits
//   done       a terminal state has been reached (pass | fail | timeout)
//   pass/fail/timeout  one-hot verdict, all 0 while not done
//   fail_addr/fail_data  store that caused FAIL, 0 otherwise
//   store_cnt  window stores accepted in RUN
//   cyc_cnt    cycles spent in RUN, saturating
// -----------------------------------------------------------------------------
module mem_write_checker #(
  parameter int XLEN       = 32,
  parameter int PASS_ADDR  = 100,
  parameter int PASS_DATA  = 25,
  parameter int IGN_BASE   = 96,
  parameter int IGN_WORDS  = 1,
  parameter int MAX_STORES = 255,
  parameter int TIMEOUT    = 10000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic            MemWrite,
  input  logic [XLEN-1:0] DataAdr,
  input  logic [XLEN-1:0] WriteData,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            timeout,
  output logic [XLEN-1:0] fail_addr,
  output logic [XLEN-1:0] fail_data,
  output logic [7:0]      store_cnt,
  output logic [31:0]     cyc_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3,
    S_TMO  = 3'd4
  } state_t;

  // Store classification codes
  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_WIN  = 2'd1;
  localparam logic [1:0] K_PASS = 2'd2;
  localparam logic [1:0] K_FAIL = 2'd3;

  localparam logic [XLEN-1:0] PASS_ADDR_V = XLEN'(PASS_ADDR);
  localparam logic [XLEN-1:0] PASS_DATA_V = XLEN'(PASS_DATA);
  // Window bounds carry one extra bit so a window ending at the top of the
  // address space does not wrap; IGN_WORDS=0 gives an empty range.
  localparam logic [XLEN:0]   WIN_LO      = (XLEN+1)'(IGN_BASE);
  localparam logic [XLEN:0]   WIN_HI      = (XLEN+1)'(IGN_BASE) + (XLEN+1)'(4 * IGN_WORDS);
  localparam logic [7:0]      MAX_CNT     = 8'(MAX_STORES);
  localparam logic            TMO_EN      = (TIMEOUT != 0);
  localparam logic [31:0]     TMO_LIMIT   = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;

  logic              mem_we;
  logic              bus_unknown;
  logic              pass_addr_hit;
  logic              pass_hit;
  logic              win_hit;
  logic [1:0]        store_kind;
  logic [31:0]       cyc_inc;
  logic              tmo_hit;

  logic [7:0]        store_cnt_nxt;
  logic [31:0]       cyc_cnt_nxt;
  logic [XLEN-1:0]   fail_addr_nxt;
  logic [XLEN-1:0]   fail_data_nxt;
  logic              pass_nxt;
  logic              fail_nxt;
  logic              timeout_nxt;
  logic              done_nxt;

  // Only a strobe that is a definite 1 counts as a store; X/Z on MemWrite
  // is ignored. Synthesis reduces the case-equality to a plain compare.
  assign mem_we = (MemWrite === 1'b1);

  // The XOR reduction of a bus with any X/Z bit is X, which matches
  // neither 0 nor 1. In hardware this term is constantly 0.
  assign bus_unknown = ((^{DataAdr, WriteData}) !== 1'b0) &&
                       ((^{DataAdr, WriteData}) !== 1'b1);

  assign pass_addr_hit = (DataAdr == PASS_ADDR_V);
  assign pass_hit      = pass_addr_hit && (WriteData == PASS_DATA_V);
  assign win_hit       = ({1'b0, DataAdr} >= WIN_LO) && ({1'b0, DataAdr} < WIN_HI);

  // Saturating increment of the RUN cycle counter
  assign cyc_inc = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : (cyc_cnt + 32'd1);

  // Timeout fires on the edge where the counter lands on TIMEOUT-1
  assign tmo_hit = TMO_EN && (cyc_inc >= TMO_LIMIT);

  // Classify the store presented this cycle, in priority order
  always_comb begin
    store_kind = K_NONE;
    if (mem_we) begin
      if (bus_unknown) begin
        store_kind = K_FAIL;
      end else if (pass_hit) begin
        store_kind = K_PASS;
      end else if (win_hit && !pass_addr_hit && (store_cnt < MAX_CNT)) begin
        // PASS_ADDR with wrong data never qualifies as a scratch store,
        // and a full window turns the store into a failure.
        store_kind = K_WIN;
      end else begin
        store_kind = K_FAIL;
      end
    end else begin
      store_kind = K_NONE;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clr overrides every other transition
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (en) begin
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        // A terminal store wins over a coincident timeout
        if (store_kind == K_PASS) begin
          state_nxt = S_PASS;
        end else if (store_kind == K_FAIL) begin
          state_nxt = S_FAIL;
        end else if (tmo_hit) begin
          state_nxt = S_TMO;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_PASS:  state_nxt = S_PASS;
      S_FAIL:  state_nxt = S_FAIL;
      S_TMO:   state_nxt = S_TMO;
      default: state_nxt = S_IDLE;
    endcase
    if (clr) begin
      state_nxt = S_IDLE;
    end else begin
      state_nxt = state_nxt;
    end
  end

  // Next values of the registered outputs
  always_comb begin
    store_cnt_nxt = store_cnt;
    cyc_cnt_nxt   = cyc_cnt;
    fail_addr_nxt = fail_addr;
    fail_data_nxt = fail_data;
    case (state)
      S_IDLE: begin
        store_cnt_nxt = 8'd0;
        cyc_cnt_nxt   = 32'd0;
        fail_addr_nxt = '0;
        fail_data_nxt = '0;
      end
      S_RUN: begin
        cyc_cnt_nxt = cyc_inc;
        if (store_kind == K_WIN) begin
          store_cnt_nxt = store_cnt + 8'd1;
        end else begin
          store_cnt_nxt = store_cnt;
        end
        if (store_kind == K_FAIL) begin
          fail_addr_nxt = DataAdr;
          fail_data_nxt = WriteData;
        end else begin
          fail_addr_nxt = '0;
          fail_data_nxt = '0;
        end
      end
      S_PASS, S_FAIL, S_TMO: begin
        // Terminal: everything frozen
        store_cnt_nxt = store_cnt;
        cyc_cnt_nxt   = cyc_cnt;
        fail_addr_nxt = fail_addr;
        fail_data_nxt = fail_data;
      end
      default: begin
        store_cnt_nxt = 8'd0;
        cyc_cnt_nxt   = 32'd0;
        fail_addr_nxt = '0;
        fail_data_nxt = '0;
      end
    endcase
    if (clr) begin
      store_cnt_nxt = 8'd0;
      cyc_cnt_nxt   = 32'd0;
      fail_addr_nxt = '0;
      fail_data_nxt = '0;
    end else begin
      store_cnt_nxt = store_cnt_nxt;
    end
  end

  // Verdict flags follow the state being entered so they appear right
  // after the edge that samples the deciding store.
  always_comb begin
    pass_nxt    = (state_nxt == S_PASS);
    fail_nxt    = (state_nxt == S_FAIL);
    timeout_nxt = (state_nxt == S_TMO);
    done_nxt    = pass_nxt | fail_nxt | timeout_nxt;
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      store_cnt <= 8'd0;
      cyc_cnt   <= 32'd0;
    end else begin
      done      <= done_nxt;
      pass      <= pass_nxt;
      fail      <= fail_nxt;
      timeout   <= timeout_nxt;
      fail_addr <= fail_addr_nxt;
      fail_data <= fail_data_nxt;
      store_cnt <= store_cnt_nxt;
      cyc_cnt   <= cyc_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker
// Directed bench for mem_write_checker (TIMEOUT=50, MAX_STORES=3, other
// parameters at their defaults). Each step pushes the expected outputs to a
// scoreboard queue, drives one cycle of stimulus, then pops and compares
// after the clock edge.
module tb_mem_write_checker;

  localparam int E_IDLE = 0;
  localparam int E_RUN  = 1;
  localparam int E_PASS = 2;
  localparam int E_FAIL = 3;
  localparam int E_TMO  = 4;

  logic        clk;
  logic        reset;
  logic        en;
  logic        clr;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [31:0] fail_addr;
  logic [31:0] fail_data;
  logic [7:0]  store_cnt;
  logic [31:0] cyc_cnt;

  typedef struct {
    string       tag;
    int          st;
    logic [7:0]  scnt;
    logic [31:0] ccnt;
    logic [31:0] fa;
    logic [31:0] fd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  mem_write_checker #(
    .XLEN(32), .PASS_ADDR(100), .PASS_DATA(25), .IGN_BASE(96),
    .IGN_WORDS(1), .MAX_STORES(3), .TIMEOUT(50)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout), .fail_addr(fail_addr),
    .fail_data(fail_data), .store_cnt(store_cnt), .cyc_cnt(cyc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string name,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %0d expected %0d", tag, name, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int st, input logic [7:0] scnt,
                      input logic [31:0] ccnt, input logic [31:0] fa,
                      input logic [31:0] fd);
    exp_t e;
    e.tag = tag; e.st = st; e.scnt = scnt; e.ccnt = ccnt; e.fa = fa; e.fd = fd;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "done",      {31'd0, done},    {31'd0, 1'(e.st >= E_PASS)});
      cmp(e.tag, "pass",      {31'd0, pass},    {31'd0, 1'(e.st == E_PASS)});
      cmp(e.tag, "fail",      {31'd0, fail},    {31'd0, 1'(e.st == E_FAIL)});
      cmp(e.tag, "timeout",   {31'd0, timeout}, {31'd0, 1'(e.st == E_TMO)});
      cmp(e.tag, "store_cnt", {24'd0, store_cnt}, {24'd0, e.scnt});
      cmp(e.tag, "cyc_cnt",   cyc_cnt,   e.ccnt);
      cmp(e.tag, "fail_addr", fail_addr, e.fa);
      cmp(e.tag, "fail_data", fail_data, e.fd);
    end
  endtask

  // One clock of stimulus followed by the scoreboard check
  task automatic step(input string tag, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic e_in, input logic c_in,
                      input int st, input logic [7:0] scnt,
                      input logic [31:0] ccnt, input logic [31:0] fa,
                      input logic [31:0] fd);
    push(tag, st, scnt, ccnt, fa, fd);
    MemWrite = we; DataAdr = a; WriteData = d; en = e_in; clr = c_in;
    @(posedge clk);
    #1;
    MemWrite = 1'b0; DataAdr = 32'd0; WriteData = 32'd0; en = 1'b0; clr = 1'b0;
    check_out();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0; MemWrite = 1'b0;
    DataAdr = 32'd0; WriteData = 32'd0;
    #12;
    push("reset_state", E_IDLE, 8'd0, 32'd0, 32'd0, 32'd0);
    check_out();
    reset = 1'b0;

    // IDLE ignores stores
    step("idle_ignore", 1'b1, 32'd104, 32'd5, 1'b0, 1'b0, E_IDLE, 8'd0, 32'd0, 32'd0, 32'd0);

    // Normal pass, sticky PASS, clr during PASS (clr beats a store)
    step("np_en",     1'b0, 32'd0,   32'd0,  1'b1, 1'b0, E_RUN,  8'd0, 32'd0, 32'd0, 32'd0);
    step("np_win",    1'b1, 32'd96,  32'd7,  1'b0, 1'b0, E_RUN,  8'd1, 32'd1, 32'd0, 32'd0);
    step("np_pass",   1'b1, 32'd100, 32'd25, 1'b0, 1'b0, E_PASS, 8'd1, 32'd2, 32'd0, 32'd0);
    step("np_sticky", 1'b1, 32'd104, 32'd1,  1'b1, 1'b0, E_PASS, 8'd1, 32'd2, 32'd0, 32'd0);
    step("np_hold",   1'b0, 32'd0,   32'd0,  1'b0, 1'b0, E_PASS, 8'd1, 32'd2, 32'd0, 32'd0);
    step("np_clr",    1'b1, 32'd104, 32'd1,  1'b0, 1'b1, E_IDLE, 8'd0, 32'd0, 32'd0, 32'd0);

    // Wrong address
    step("wa_en",     1'b0, 32'd0,   32'd0,  1'b1, 1'b0, E_RUN,  8'd0, 32'd0, 32'd0,   32'd0);
    step("wa_store",  1'b1, 32'd104, 32'd25, 1'b0, 1'b0, E_FAIL, 8'd0, 32'd1, 32'd104, 32'd25);
    step("wa_sticky", 1'b1, 32'd100, 32'd25, 1'b0, 1'b0, E_FAIL, 8'd0, 32'd1, 32'd104, 32'd25);
    step("wa_clr",    1'b0, 32'd0,   32'd0,  1'b0, 1'b1, E_IDLE, 8'd0, 32'd0, 32'd0,   32'd0);

    // Wrong data at PASS_ADDR
    step("wd_en",     1'b0, 32'd0,   32'd0,  1'b1, 1'b0, E_RUN,  8'd0, 32'd0, 32'd0,   32'd0);
    step("wd_store",  1'b1, 32'd100, 32'd24, 1'b0, 1'b0, E_FAIL, 8'd0, 32'd1, 32'd100, 32'd24);
    step("wd_clr",    1'b0, 32'd0,   32'd0,  1'b0, 1'b1, E_IDLE, 8'd0, 32'd0, 32'd0,   32'd0);

    // Window edges: 99 is inside, 95 is below
    step("wb_en",     1'b0, 32'd0,   32'd0,  1'b1, 1'b0, E_RUN,  8'd0, 32'd0, 32'd0,  32'd0);
    step("wb_top",    1'b1, 32'd99,  32'd1,  1'b0, 1'b0, E_RUN,  8'd1, 32'd1, 32'd0,  32'd0);
    step("wb_below",  1'b1, 32'd95,  32'd3,  1'b0, 1'b0, E_FAIL, 8'd1, 32'd2, 32'd95, 32'd3);
    step("wb_clr",    1'b0, 32'd0,   32'd0,  1'b0, 1'b1, E_IDLE, 8'd0, 32'd0, 32'd0,  32'd0);

    // clr beats en and a store on the same edge
    step("clr_en",    1'b1, 32'd100, 32'd25, 1'b1, 1'b1, E_IDLE, 8'd0, 32'd0, 32'd0, 32'd0);
    // clr beats a failing store in RUN
    step("cr_en",     1'b0, 32'd0,   32'd0,  1'b1, 1'b0, E_RUN,  8'd0, 32'd0, 32'd0, 32'd0);
    step("cr_store",  1'b1, 32'd104, 32'd9,  1'b0, 1'b1, E_IDLE, 8'd0, 32'd0, 32'd0, 32'd0);

    // Window overflow with MAX_STORES=3
    step("ov_en",     1'b0, 32'd0,   32'd0,  1'b1, 1'b0, E_RUN,  8'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step("ov_win", 1'b1, 32'd96, 32'(i), 1'b0, 1'b0, E_RUN, 8'(i), 32'(i), 32'd0, 32'd0);
    end
    step("ov_fourth", 1'b1, 32'd96,  32'd4,  1'b0, 1'b0, E_FAIL, 8'd3, 32'd4, 32'd96, 32'd4);
    step("ov_clr",    1'b0, 32'd0,   32'd0,  1'b0, 1'b1, E_IDLE, 8'd0, 32'd0, 32'd0,  32'd0);

    // Timeout at cyc_cnt=49, later PASS store ignored
    step("to_en",     1'b0, 32'd0,   32'd0,  1'b1, 1'b0, E_RUN,  8'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 1; i <= 48; i++) begin
      step("to_run", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, E_RUN, 8'd0, 32'(i), 32'd0, 32'd0);
    end
    step("to_hit",    1'b0, 32'd0,   32'd0,  1'b0, 1'b0, E_TMO,  8'd0, 32'd49, 32'd0, 32'd0);
    step("to_late",   1'b1, 32'd100, 32'd25, 1'b1, 1'b0, E_TMO,  8'd0, 32'd49, 32'd0, 32'd0);
    step("to_clr",    1'b0, 32'd0,   32'd0,  1'b0, 1'b1, E_IDLE, 8'd0, 32'd0,  32'd0, 32'd0);

    // PASS store coinciding with the timeout edge wins
    step("tw_en",     1'b0, 32'd0,   32'd0,  1'b1, 1'b0, E_RUN,  8'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 1; i <= 48; i++) begin
      step("tw_run", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, E_RUN, 8'd0, 32'(i), 32'd0, 32'd0);
    end
    step("tw_pass",   1'b1, 32'd100, 32'd25, 1'b0, 1'b0, E_PASS, 8'd0, 32'd49, 32'd0, 32'd0);
    step("tw_clr",    1'b0, 32'd0,   32'd0,  1'b0, 1'b1, E_IDLE, 8'd0, 32'd0,  32'd0, 32'd0);

    // Asynchronous reset mid-RUN, between clock edges
    step("rs_en",     1'b0, 32'd0,   32'd0,  1'b1, 1'b0, E_RUN,  8'd0, 32'd0, 32'd0, 32'd0);
    step("rs_win",    1'b1, 32'd96,  32'd1,  1'b0, 1'b0, E_RUN,  8'd1, 32'd1, 32'd0, 32'd0);
    step("rs_run",    1'b0, 32'd0,   32'd0,  1'b0, 1'b0, E_RUN,  8'd1, 32'd2, 32'd0, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    push("rs_async", E_IDLE, 8'd0, 32'd0, 32'd0, 32'd0);
    check_out();
    #1;
    reset = 1'b0;
    step("rs_idle",   1'b0, 32'd0,   32'd0,  1'b0, 1'b0, E_IDLE, 8'd0, 32'd0, 32'd0, 32'd0);
    step("rs_noen",   1'b1, 32'd104, 32'd2,  1'b0, 1'b0, E_IDLE, 8'd0, 32'd0, 32'd0, 32'd0);
    step("rs_reen",   1'b0, 32'd0,   32'd0,  1'b1, 1'b0, E_RUN,  8'd0, 32'd0, 32'd0, 32'd0);
    step("rs_pass",   1'b1, 32'd100, 32'd25, 1'b0, 1'b0, E_PASS, 8'd0, 32'd1, 32'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
